// File: rtl/serial_pkg.sv
// Shared definitions for the serializer family: state encoding and the
// counter-width helper, reused by the PISO stage and a future SIPO stage.
package serial_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  // Ceiling log2. Returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // A bit counter needs at least one bit even for degenerate widths.
  function automatic int cnt_width(input int width);
    return (clog2(width) < 1) ? 1 : clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// Shift register and bit counter of the PISO serializer, plus the serial
// output mux. The top decides when to load; this block just executes.
module piso_shift_core
  import serial_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             active,
  input  logic [WIDTH-1:0] load_word,
  output logic             serial_out,
  output logic [CW-1:0]    cnt,
  output logic             cnt_last
);

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_shifted;

  // Move every bit one place toward the output end, zero-filling the far end.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
    if (MSB_FIRST) begin : g_msb
      if (gi == 0) begin : g_fill
        assign sh_shifted[gi] = 1'b0;
      end else begin : g_move
        assign sh_shifted[gi] = sh[gi-1];
      end
    end else begin : g_lsb
      if (gi == WIDTH - 1) begin : g_fill
        assign sh_shifted[gi] = 1'b0;
      end else begin : g_move
        assign sh_shifted[gi] = sh[gi+1];
      end
    end
  end

  assign cnt_last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      sh  <= load_word;
      cnt <= '0;
    end else if (active) begin
      sh  <= sh_shifted;
      cnt <= cnt_last ? '0 : cnt + 1'b1;
    end
  end

  assign serial_out = active ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : 1'b0;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready input and a one-word
// holding buffer so consecutive frames stream without an idle bit.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  logic             state;
  logic [WIDTH-1:0] hold;
  logic             hold_v;
  logic [CW-1:0]    cnt;
  logic             cnt_last;
  logic             transfer;
  logic             last;
  logic             load_edge;
  logic             load;
  logic [WIDTH-1:0] load_word;

  assign data_ready = !hold_v;
  assign transfer   = data_valid && data_ready;
  assign last       = (state == ST_SHIFT) && cnt_last;
  assign load_edge  = (state == ST_IDLE) || last;
  // A held word always has priority over a bypass so ordering is preserved.
  assign load       = load_edge && (hold_v || transfer);
  assign load_word  = hold_v ? hold : data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      hold   <= '0;
      hold_v <= 1'b0;
    end else if (load_edge) begin
      state <= load ? ST_SHIFT : ST_IDLE;
      if (hold_v) begin
        hold_v <= transfer;
        if (transfer) hold <= data;
      end
    end else if (transfer) begin
      hold   <= data;
      hold_v <= 1'b1;
    end
  end

  piso_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .active     (state == ST_SHIFT),
    .load_word  (load_word),
    .serial_out (serial_out),
    .cnt        (cnt),
    .cnt_last   (cnt_last)
  );

  assign serial_valid = (state == ST_SHIFT);
  assign frame_start  = (state == ST_SHIFT) && (cnt == '0);
  assign frame_end    = last;
  assign busy         = (state == ST_SHIFT) || hold_v;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first instance for most steps and an
// LSB-first instance for bit-order checking.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] data;
  logic       data_valid;
  logic       data_ready, serial_out, serial_valid, frame_start, frame_end, busy;
  logic [3:0] l_data;
  logic       l_valid;
  logic       l_ready, l_out, l_svalid, l_fstart, l_fend, l_busy;

  int         checks = 0;
  int         errors = 0;
  int         widx;
  logic       xfer;
  logic [3:0] words [3];
  logic [11:0] stream;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .data         (data),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .busy         (busy)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk          (clk),
    .reset        (reset),
    .data         (l_data),
    .data_valid   (l_valid),
    .data_ready   (l_ready),
    .serial_out   (l_out),
    .serial_valid (l_svalid),
    .frame_start  (l_fstart),
    .frame_end    (l_fend),
    .busy         (l_busy)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed as {serial_valid, serial_out, frame_start, frame_end}.
  task automatic expect_bit(input string tag, input logic so, input logic fs, input logic fe);
    check(tag, {serial_valid, serial_out, frame_start, frame_end}, {1'b1, so, fs, fe});
  endtask

  // Packed as {serial_out, serial_valid, frame_start, frame_end, busy, data_ready}.
  task automatic expect_idle(input string tag);
    check(tag, {serial_out, serial_valid, frame_start, frame_end, busy, data_ready}, 8'b000001);
  endtask

  initial begin
    reset      = 1'b1;
    data       = 4'b1111;
    data_valid = 1'b1;
    l_data     = 4'b0000;
    l_valid    = 1'b0;

    // Reset held two cycles with data_valid asserted.
    tick();
    expect_idle("reset_cycle1");
    tick();
    expect_idle("reset_cycle2");
    reset      = 1'b0;
    data_valid = 1'b0;
    #1;
    expect_idle("after_reset");
    tick();
    expect_idle("no_frame_after_reset");

    // Single word 1010.
    data       = 4'b1010;
    data_valid = 1'b1;
    tick();
    $display("single: accepted word %b", data);
    data_valid = 1'b0;
    expect_bit("single_b0", 1'b1, 1'b1, 1'b0);
    check("single_busy", busy, 1'b1);
    tick(); expect_bit("single_b1", 1'b0, 1'b0, 1'b0);
    tick(); expect_bit("single_b2", 1'b1, 1'b0, 1'b0);
    tick(); expect_bit("single_b3", 1'b0, 1'b0, 1'b1);
    tick(); expect_idle("single_done");

    // Back-to-back 0111 then 0110, second word goes through the hold buffer.
    data       = 4'b0111;
    data_valid = 1'b1;
    tick();
    $display("b2b: accepted word %b", data);
    data = 4'b0110;
    expect_bit("b2b_a0", 1'b0, 1'b1, 1'b0);
    check("b2b_ready_before_hold", data_ready, 1'b1);
    tick();
    $display("b2b: accepted word %b into hold", data);
    data_valid = 1'b0;
    expect_bit("b2b_a1", 1'b1, 1'b0, 1'b0);
    check("b2b_ready_held1", data_ready, 1'b0);
    tick(); expect_bit("b2b_a2", 1'b1, 1'b0, 1'b0);
    check("b2b_ready_held2", data_ready, 1'b0);
    tick(); expect_bit("b2b_a3", 1'b1, 1'b0, 1'b1);
    check("b2b_ready_held3", data_ready, 1'b0);
    tick(); expect_bit("b2b_b0", 1'b0, 1'b1, 1'b0);
    check("b2b_ready_drained", data_ready, 1'b1);
    tick(); expect_bit("b2b_b1", 1'b1, 1'b0, 1'b0);
    tick(); expect_bit("b2b_b2", 1'b1, 1'b0, 1'b0);
    tick(); expect_bit("b2b_b3", 1'b0, 1'b0, 1'b1);
    tick(); expect_idle("b2b_done");

    // Stall: data_valid held high, data advances only after each acceptance.
    words[0]   = 4'b1001;
    words[1]   = 4'b0100;
    words[2]   = 4'b1110;
    stream     = 12'b1001_0100_1110;
    widx       = 0;
    data       = words[0];
    data_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      xfer = data_valid && data_ready;
      tick();
      if (xfer) begin
        $display("stall: accepted word %0d = %b", widx, data);
        widx++;
        if (widx < 3) begin
          data = words[widx];
        end else begin
          data_valid = 1'b0;
          data       = 4'b0000;
        end
      end
      expect_bit("stall_bit", stream[11-i], (i % 4) == 0, (i % 4) == 3);
    end
    check("stall_words_accepted", 8'(widx), 8'd3);
    tick(); expect_idle("stall_done");

    // Bypass: next word offered exactly at the last edge with hold empty.
    data       = 4'b1100;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    expect_bit("bypass_a0", 1'b1, 1'b1, 1'b0);
    tick(); expect_bit("bypass_a1", 1'b1, 1'b0, 1'b0);
    tick(); expect_bit("bypass_a2", 1'b0, 1'b0, 1'b0);
    tick(); expect_bit("bypass_a3", 1'b0, 1'b0, 1'b1);
    data       = 4'b0011;
    data_valid = 1'b1;
    tick();
    $display("bypass: accepted word %b at last edge", data);
    data_valid = 1'b0;
    expect_bit("bypass_b0", 1'b0, 1'b1, 1'b0);
    check("bypass_ready", data_ready, 1'b1);
    tick(); expect_bit("bypass_b1", 1'b0, 1'b0, 1'b0);
    tick(); expect_bit("bypass_b2", 1'b1, 1'b0, 1'b0);
    tick(); expect_bit("bypass_b3", 1'b1, 1'b0, 1'b1);
    tick(); expect_idle("bypass_done");

    // Reset mid-frame with a word held.
    data       = 4'b1100;
    data_valid = 1'b1;
    tick();
    data = 4'b0001;
    expect_bit("midrst_b0", 1'b1, 1'b1, 1'b0);
    tick();
    $display("midrst: word %b held", data);
    expect_bit("midrst_b1", 1'b1, 1'b0, 1'b0);
    check("midrst_held", data_ready, 1'b0);
    reset = 1'b1;
    tick();
    expect_idle("midrst_after_reset");
    reset      = 1'b0;
    data_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_no_emit", {serial_valid, frame_end, busy}, 3'b000);
    end

    // LSB-first instance, word 0011.
    l_data  = 4'b0011;
    l_valid = 1'b1;
    tick();
    $display("lsb: accepted word %b", l_data);
    l_valid = 1'b0;
    check("lsb_b0", {l_svalid, l_out, l_fstart, l_fend}, 4'b1110);
    tick(); check("lsb_b1", {l_svalid, l_out, l_fstart, l_fend}, 4'b1100);
    tick(); check("lsb_b2", {l_svalid, l_out, l_fstart, l_fend}, 4'b1000);
    tick(); check("lsb_b3", {l_svalid, l_out, l_fstart, l_fend}, 4'b1001);
    tick(); check("lsb_done", {l_svalid, l_out, l_busy, l_ready}, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
